// File: rtl/m_ram_arb_pkg.sv
// Shared types and constants for the shared-RAM arbiter: FSM states, owner
// encodings and the legal ranges of the timing parameters.
package m_ram_arb_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WCNT_W = 3;
    localparam int unsigned BCNT_W = 4;

    localparam int unsigned WAIT_CYCLES_MIN = 1;
    localparam int unsigned WAIT_CYCLES_MAX = 7;
    localparam int unsigned SS_BURST_MIN    = 1;
    localparam int unsigned SS_BURST_HI     = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_SS   = 2'd2;

endpackage

// File: rtl/m_ram_arbiter.sv
// Arbitrates the single external RAM port between the 8088 bus interface and
// the Slipstream master, with Slipstream priority and a CPU starvation guard.
module m_ram_arbiter
    import m_ram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned SS_BURST_MAX = 8
) (
    input  logic                FCLK,
    input  logic                RESET_n,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_we,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_ack,
    output logic [7:0]          cpu_rdata,
    input  logic                ss_req,
    input  logic [ADDR_W-1:0]   ss_addr,
    input  logic                ss_we,
    input  logic                ss_word,
    input  logic [DATA_W-1:0]   ss_wdata,
    output logic                ss_ack,
    output logic [DATA_W-1:0]   ss_rdata,
    output logic [ADDR_W-1:0]   ABus,
    output logic                Write,
    output logic                Word,
    output logic [DATA_W-1:0]   outRamData,
    input  logic [DATA_W-1:0]   inRamData,
    output logic [1:0]          owner
);

    if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
        $error("m_ram_arbiter: WAIT_CYCLES out of range 1..7");
    end
    if (SS_BURST_MAX < SS_BURST_MIN || SS_BURST_MAX > SS_BURST_HI) begin : g_bad_burst
        $error("m_ram_arbiter: SS_BURST_MAX out of range 1..15");
    end

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(SS_BURST_MAX);

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [BCNT_W-1:0]   r_burst_cnt;
    logic                w_burst_full;
    logic                w_grant_ss;

    // Slipstream wins unless it has used up its burst while the CPU waits
    assign w_burst_full = (r_burst_cnt == BURST_LIM);
    assign w_grant_ss   = ss_req && !(w_burst_full && cpu_req);

    // The bus output registers double as the latched transaction fields
    always_ff @(posedge FCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
            owner       <= OWN_NONE;
            cpu_ack     <= 1'b0;
            ss_ack      <= 1'b0;
            cpu_rdata   <= '0;
            ss_rdata    <= '0;
            ABus        <= '0;
            Write       <= 1'b0;
            Word        <= 1'b0;
            outRamData  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ss_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_ss) begin
                        owner      <= OWN_SS;
                        ABus       <= ss_addr;
                        Write      <= ss_we;
                        Word       <= ss_word;
                        outRamData <= ss_wdata;
                        r_wait_cnt <= '0;
                        r_state    <= ACCESS;
                    end else if (cpu_req) begin
                        owner      <= OWN_CPU;
                        ABus       <= cpu_addr;
                        Write      <= cpu_we;
                        Word       <= 1'b0;
                        outRamData <= {8'h00, cpu_wdata};
                        r_wait_cnt <= '0;
                        r_state    <= ACCESS;
                    end
                    // Burst count only tracks Slipstream grants taken while the CPU waits
                    if (!cpu_req) begin
                        r_burst_cnt <= '0;
                    end else if (w_grant_ss) begin
                        if (!w_burst_full) begin
                            r_burst_cnt <= BCNT_W'(r_burst_cnt + 4'd1);
                        end
                    end else begin
                        r_burst_cnt <= '0;
                    end
                end
                ACCESS: begin
                    r_wait_cnt <= WCNT_W'(r_wait_cnt + 3'd1);
                    if (r_wait_cnt == WAIT_LAST) begin
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!Write) begin
                                cpu_rdata <= inRamData[7:0];
                            end
                        end else begin
                            ss_ack <= 1'b1;
                            if (!Write) begin
                                ss_rdata <= inRamData;
                            end
                        end
                        owner      <= OWN_NONE;
                        ABus       <= '0;
                        Write      <= 1'b0;
                        Word       <= 1'b0;
                        outRamData <= '0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_ram_arbiter.sv
// Scoreboard bench for m_ram_arbiter: per-requester expectation queues, a RAM
// model driving inRamData from ABus, and a negedge bus/ack monitor.
module tb_m_ram_arbiter;

    localparam int unsigned WC  = 2;
    localparam int unsigned SBM = 8;

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic        word;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        FCLK;
    logic        RESET_n;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ss_req;
    logic [19:0] ss_addr;
    logic        ss_we;
    logic        ss_word;
    logic [15:0] ss_wdata;
    logic        ss_ack;
    logic [15:0] ss_rdata;
    logic [19:0] ABus;
    logic        Write;
    logic        Word;
    logic [15:0] outRamData;
    logic [15:0] inRamData;
    logic [1:0]  owner;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   wr_cycles;
    int   busy_cycles;
    exp_t cpu_q[$];
    exp_t ss_q[$];
    int   owner_trace[$];
    int   ack_log[$];
    logic [7:0]  last_cpu;
    logic [15:0] last_ss;
    logic [1:0]  prev_owner;
    exp_t mon_e;

    m_ram_arbiter #(.WAIT_CYCLES(WC), .SS_BURST_MAX(SBM)) dut (
        .FCLK(FCLK), .RESET_n(RESET_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ss_req(ss_req), .ss_addr(ss_addr), .ss_we(ss_we), .ss_word(ss_word),
        .ss_wdata(ss_wdata), .ss_ack(ss_ack), .ss_rdata(ss_rdata),
        .ABus(ABus), .Write(Write), .Word(Word), .outRamData(outRamData),
        .inRamData(inRamData), .owner(owner)
    );

    function automatic logic [15:0] ram_val(input logic [19:0] a);
        if (a == 20'h12345) return 16'hBEEF;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ a[19:12]};
    endfunction

    assign inRamData = ram_val(ABus);

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;
    always @(posedge FCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string who, input exp_t e);
        check({who, "_abus"}, 32'(ABus), 32'(e.addr));
        check({who, "_write"}, 32'(Write), 32'(e.we));
        check({who, "_word"}, 32'(Word), 32'(e.word));
        check({who, "_wdata"}, 32'(outRamData), 32'(e.wdata));
    endtask

    task automatic check_released(input string who);
        check({who, "_done_owner"}, 32'(owner), 32'd0);
        check({who, "_done_write"}, 32'(Write), 32'd0);
        check({who, "_done_abus"}, 32'(ABus), 32'd0);
        check({who, "_done_word"}, 32'(Word), 32'd0);
        check({who, "_done_odata"}, 32'(outRamData), 32'd0);
    endtask

    // Monitor: bus contents vs queue head, ack payloads, ack exclusivity
    always @(negedge FCLK) begin
        if (!RESET_n) begin
            last_cpu   = '0;
            last_ss    = '0;
            prev_owner = 2'd0;
        end else begin
            check("ack_excl", 32'(cpu_ack & ss_ack), 32'd0);
            if (owner != prev_owner) owner_trace.push_back(int'(owner));
            prev_owner = owner;
            if (owner != 2'd0) busy_cycles++;
            if (Write) wr_cycles++;
            if (owner == 2'd1 && cpu_q.size() != 0) check_bus("cpu", cpu_q[0]);
            if (owner == 2'd2 && ss_q.size() != 0) check_bus("ss", ss_q[0]);
            if (cpu_ack) begin
                ack_log.push_back(1);
                check_released("cpu");
                if (cpu_q.size() == 0) begin
                    check("cpu_ack_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = cpu_q.pop_front();
                    if (!mon_e.we) last_cpu = mon_e.rdata[7:0];
                    check("cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
                end
            end
            if (ss_ack) begin
                ack_log.push_back(2);
                check_released("ss");
                if (ss_q.size() == 0) begin
                    check("ss_ack_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = ss_q.pop_front();
                    if (!mon_e.we) last_ss = mon_e.rdata;
                    check("ss_rdata", 32'(ss_rdata), 32'(last_ss));
                end
            end
        end
    end

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    task automatic cpu_start(input logic [19:0] a, input logic we, input logic [7:0] d);
        exp_t e;
        logic [15:0] v;
        v = ram_val(a);
        e.addr = a; e.we = we; e.word = 1'b0; e.wdata = {8'h00, d}; e.rdata = {8'h00, v[7:0]};
        cpu_q.push_back(e);
        cpu_addr = a; cpu_we = we; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic ss_start(input logic [19:0] a, input logic we, input logic wd, input logic [15:0] d);
        exp_t e;
        e.addr = a; e.we = we; e.word = wd; e.wdata = d; e.rdata = ram_val(a);
        ss_q.push_back(e);
        ss_addr = a; ss_we = we; ss_word = wd; ss_wdata = d; ss_req = 1'b1;
    endtask

    task automatic cpu_wait(output int at);
        bit got = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (cpu_ack) begin got = 1'b1; at = cyc; end
        end
        if (!got) check("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic ss_wait(output int at);
        bit got = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (ss_ack) begin got = 1'b1; at = cyc; end
        end
        if (!got) check("ss_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic cpu_txn(input logic [19:0] a, input logic we, input logic [7:0] d);
        int t;
        cpu_start(a, we, d);
        cpu_wait(t);
        cpu_req = 1'b0;
    endtask

    task automatic ss_txn(input logic [19:0] a, input logic we, input logic wd, input logic [15:0] d);
        int t;
        ss_start(a, we, wd, d);
        ss_wait(t);
        ss_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, n_ss_first;
        RESET_n = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        ss_req = 1'b0; ss_addr = '0; ss_we = 1'b0; ss_word = 1'b0; ss_wdata = '0;
        wr_cycles = 0; busy_cycles = 0;
        repeat (3) tick();
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_acks", 32'({cpu_ack, ss_ack}), 32'd0);
        check("rst_bus", 32'({Write, Word, ABus}), 32'd0);
        check("rst_odata", 32'(outRamData), 32'd0);
        check("rst_rdata", 32'({cpu_rdata, ss_rdata}), 32'd0);
        RESET_n = 1'b1;
        tick();

        // CPU read, latency and access length
        busy_cycles = 0;
        t0 = cyc;
        cpu_start(20'h12345, 1'b0, 8'h00);
        cpu_wait(t1);
        cpu_req = 1'b0;
        check("cpu_read_latency", 32'(t1 - t0), 32'(WC + 1));
        check("cpu_rdata_ef", 32'(cpu_rdata), 32'h0EF);
        tick(); tick();
        check("cpu_busy_cycles", 32'(busy_cycles), 32'(WC));

        // SS word write
        wr_cycles = 0;
        ss_txn(20'h0A000, 1'b1, 1'b1, 16'h55AA);
        check("ss_write_done_strobe", 32'(Write), 32'd0);
        tick(); tick();
        check("ss_write_cycles", 32'(wr_cycles), 32'(WC));

        // SS byte read returns full inRamData; CPU write holds cpu_rdata
        ss_txn(20'h00301, 1'b0, 1'b0, 16'h0000);
        check("ss_rdata_val", 32'(ss_rdata), 32'(ram_val(20'h00301)));
        tick();
        cpu_txn(20'h00011, 1'b1, 8'h77);
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'h0EF);
        tick(); tick();

        // Simultaneous requests: SS first, then CPU
        owner_trace.delete();
        fork
            cpu_txn(20'h22222, 1'b0, 8'h00);
            ss_txn(20'h33333, 1'b0, 1'b1, 16'h0000);
        join
        tick(); tick();
        check("sim_trace_len", 32'(owner_trace.size()), 32'd4);
        if (owner_trace.size() == 4) begin
            check("sim_trace0", 32'(owner_trace[0]), 32'd2);
            check("sim_trace1", 32'(owner_trace[1]), 32'd0);
            check("sim_trace2", 32'(owner_trace[2]), 32'd1);
            check("sim_trace3", 32'(owner_trace[3]), 32'd0);
        end

        // Starvation guard: SS held continuously, CPU waiting
        ack_log.delete();
        fork
            cpu_txn(20'h44444, 1'b0, 8'h00);
            begin
                for (int k = 0; k < 10; k++) begin
                    ss_start(20'h50000 + 20'(k), 1'b0, 1'b1, 16'h0000);
                    ss_wait(t2);
                end
                ss_req = 1'b0;
            end
        join
        tick(); tick();
        n_ss_first = 0;
        while (n_ss_first < ack_log.size() && ack_log[n_ss_first] == 2) n_ss_first++;
        check("starve_log_len", 32'(ack_log.size()), 32'd11);
        check("starve_ss_burst", 32'(n_ss_first), 32'(SBM));
        if (ack_log.size() == 11) begin
            check("starve_cpu_slot", 32'(ack_log[8]), 32'd1);
            check("starve_ss_resume", 32'(ack_log[9]), 32'd2);
        end

        // Held request: DONE ignores it, next grant one IDLE later
        cpu_start(20'h06060, 1'b0, 8'h00);
        cpu_wait(t1);
        cpu_start(20'h06060, 1'b0, 8'h00);
        cpu_wait(t2);
        cpu_req = 1'b0;
        check("b2b_period", 32'(t2 - t1), 32'(WC + 2));
        tick(); tick();

        // Reset mid-ACCESS
        ack_log.delete();
        cpu_addr = 20'h0ABCD; cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_req = 1'b1;
        tick();
        check("pre_rst_owner", 32'(owner), 32'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        check("rst_mid_owner", 32'(owner), 32'd0);
        check("rst_mid_abus", 32'(ABus), 32'd0);
        check("rst_mid_ctl", 32'({Write, Word, cpu_ack, ss_ack}), 32'd0);
        check("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
        tick(); tick();
        check("rst_mid_no_ack", 32'(ack_log.size()), 32'd0);
        RESET_n = 1'b1;
        t0 = cyc;
        cpu_start(20'h0ABCD, 1'b0, 8'h00);
        cpu_wait(t1);
        cpu_req = 1'b0;
        check("post_rst_latency", 32'(t1 - t0), 32'(WC + 1));
        check("post_rst_rdata", 32'(cpu_rdata), 32'(8'(ram_val(20'h0ABCD))));
        tick(); tick();

        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("ss_q_empty", 32'(ss_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
